// File: rtl/cond_unit_pkg.sv
// Shared condition-unit definitions: ARM condition codes,
// NZCV flag bit positions and flag-write enable bit meanings.
package cond_unit_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // flag_w bit 1 loads N,Z; bit 0 loads C,V
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition check of cond against NZCV flags.
// Ports: cond[3:0], flags[3:0] (N,Z,C,V) in; cond_ex out.
module cond_check
  import cond_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    unique case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: NZCV register, predication of
// write controls, E->M control registers, condition-fail counter.
// Ports: clk, reset_n, valid/stall/flush_e, cond_e, alu_flags,
// flag_w_e, pcs/reg_w/mem_w_e in; cond_ex_e, pc_src_e,
// reg/mem_write_m, pc_src_m, flags, fail_count out.
module cond_unit
  import cond_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_e,
  input  logic             stall_e,
  input  logic             flush_e,
  input  logic [3:0]       cond_e,
  input  logic [3:0]       alu_flags,
  input  logic [1:0]       flag_w_e,
  input  logic             pcs_e,
  input  logic             reg_w_e,
  input  logic             mem_w_e,
  output logic             cond_ex_e,
  output logic             pc_src_e,
  output logic             reg_write_m,
  output logic             mem_write_m,
  output logic             pc_src_m,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] fail_count
);

  logic go;
  logic live;
  logic reg_w_g;
  logic mem_w_g;
  logic upd;

  cond_check u_check (
    .cond    (cond_e),
    .flags   (flags),
    .cond_ex (cond_ex_e)
  );

  assign live     = valid_e & ~flush_e;
  assign go       = live & cond_ex_e;
  assign pc_src_e = pcs_e & go;
  assign reg_w_g  = reg_w_e & go;
  assign mem_w_g  = mem_w_e & go;
  assign upd      = go & ~stall_e;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags <= 4'b0000;
    end else if (upd) begin
      if (flag_w_e[FLAGW_NZ]) begin
        flags[FLAG_N] <= alu_flags[FLAG_N];
        flags[FLAG_Z] <= alu_flags[FLAG_Z];
      end
      if (flag_w_e[FLAGW_CV]) begin
        flags[FLAG_C] <= alu_flags[FLAG_C];
        flags[FLAG_V] <= alu_flags[FLAG_V];
      end
    end
  end

  // flush wins over stall so a squashed slot becomes a bubble
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_write_m <= 1'b0;
      mem_write_m <= 1'b0;
      pc_src_m    <= 1'b0;
    end else if (flush_e) begin
      reg_write_m <= 1'b0;
      mem_write_m <= 1'b0;
      pc_src_m    <= 1'b0;
    end else if (!stall_e) begin
      reg_write_m <= reg_w_g;
      mem_write_m <= mem_w_g;
      pc_src_m    <= pc_src_e;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fail_count <= '0;
    end else if (live && !stall_e && !cond_ex_e
                 && !(&fail_count)) begin
      fail_count <= fail_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: driver pushes model results,
// monitors pop and compare comb and registered outputs.
module tb_cond_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_e, stall_e, flush_e;
  logic [3:0]  cond_e, alu_flags;
  logic [1:0]  flag_w_e;
  logic        pcs_e, reg_w_e, mem_w_e;
  logic        cond_ex_e, pc_src_e;
  logic        reg_write_m, mem_write_m, pc_src_m;
  logic [3:0]  flags;
  logic [15:0] fail_count;

  cond_unit #(.CNT_W(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .valid_e     (valid_e),
    .stall_e     (stall_e),
    .flush_e     (flush_e),
    .cond_e      (cond_e),
    .alu_flags   (alu_flags),
    .flag_w_e    (flag_w_e),
    .pcs_e       (pcs_e),
    .reg_w_e     (reg_w_e),
    .mem_w_e     (mem_w_e),
    .cond_ex_e   (cond_ex_e),
    .pc_src_e    (pc_src_e),
    .reg_write_m (reg_write_m),
    .mem_write_m (mem_write_m),
    .pc_src_m    (pc_src_m),
    .flags       (flags),
    .fail_count  (fail_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ce;
    logic pcs;
  } comb_t;

  typedef struct {
    logic [3:0]  fl;
    logic        rw;
    logic        mw;
    logic        pc;
    logic [15:0] cnt;
  } st_t;

  comb_t qc[$];
  st_t   qs[$];

  int passed = 0;
  int total  = 0;

  logic [3:0]  mfl;
  logic        mrw, mmw, mpc;
  logic [15:0] mcnt;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h @%0t",
                  nm, act, exp, $time);
  endtask

  // Conditions come in complementary pairs: even code is the
  // base test, odd code is its negation (AL/NV included).
  function automatic logic ref_cond(input logic [3:0] c,
                                    input logic [3:0] f);
    bit n, z, cy, v, b;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c >> 1)
      0: b = z;
      1: b = cy;
      2: b = n;
      3: b = v;
      4: b = cy && !z;
      5: b = (n == v);
      6: b = !z && (n == v);
      default: b = 1;
    endcase
    return b ^ c[0];
  endfunction

  task automatic step(input logic v, input logic st,
                      input logic fl, input logic [3:0] c,
                      input logic [3:0] af, input logic [1:0] fw,
                      input logic ps, input logic rw,
                      input logic mw);
    comb_t e;
    st_t   s;
    logic  ce, go;
    @(negedge clk);
    valid_e = v; stall_e = st; flush_e = fl;
    cond_e = c; alu_flags = af; flag_w_e = fw;
    pcs_e = ps; reg_w_e = rw; mem_w_e = mw;
    ce = ref_cond(c, mfl);
    go = v && !fl && ce;
    e.ce = ce;
    e.pcs = ps && go;
    qc.push_back(e);
    if (go && !st) begin
      if (fw[1]) mfl[3:2] = af[3:2];
      if (fw[0]) mfl[1:0] = af[1:0];
    end
    if (fl) begin
      mrw = 0; mmw = 0; mpc = 0;
    end else if (!st) begin
      mrw = rw && go; mmw = mw && go; mpc = ps && go;
    end
    if (v && !fl && !st && !ce && mcnt != 16'hFFFF)
      mcnt = mcnt + 1;
    s.fl = mfl; s.rw = mrw; s.mw = mmw;
    s.pc = mpc; s.cnt = mcnt;
    qs.push_back(s);
  endtask

  task automatic idle();
    step(0, 0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    valid_e = 0; stall_e = 0; flush_e = 0;
    #3 reset_n = 0;
    #1;
    mfl = 0; mrw = 0; mmw = 0; mpc = 0; mcnt = 0;
    chk("rst_flags", 16'(flags), 16'h0);
    chk("rst_rw", 16'(reg_write_m), 16'h0);
    chk("rst_mw", 16'(mem_write_m), 16'h0);
    chk("rst_pc", 16'(pc_src_m), 16'h0);
    chk("rst_cnt", fail_count, 16'h0);
    @(negedge clk);
    #1 reset_n = 1;
  endtask

  initial begin : comb_mon
    comb_t e;
    forever begin
      @(negedge clk);
      #2;
      if (qc.size() > 0) begin
        e = qc.pop_front();
        chk("cond_ex_e", 16'(cond_ex_e), 16'(e.ce));
        chk("pc_src_e", 16'(pc_src_e), 16'(e.pcs));
      end
    end
  end

  initial begin : st_mon
    st_t s;
    forever begin
      @(posedge clk);
      #1;
      if (qs.size() > 0) begin
        s = qs.pop_front();
        chk("flags", 16'(flags), 16'(s.fl));
        chk("reg_write_m", 16'(reg_write_m), 16'(s.rw));
        chk("mem_write_m", 16'(mem_write_m), 16'(s.mw));
        chk("pc_src_m", 16'(pc_src_m), 16'(s.pc));
        chk("fail_count", fail_count, s.cnt);
      end
    end
  end

  initial begin : drv
    int w;
    reset_n = 0;
    valid_e = 0; stall_e = 0; flush_e = 0;
    cond_e = 4'hE; alu_flags = 0; flag_w_e = 0;
    pcs_e = 0; reg_w_e = 0; mem_w_e = 0;
    mfl = 0; mrw = 0; mmw = 0; mpc = 0; mcnt = 0;
    #12 reset_n = 1;

    // async reset mid-stream with all flags set
    step(1, 0, 0, 4'hE, 4'hF, 2'b11, 1, 1, 1);
    do_reset();

    // CMP then BEQ
    step(1, 0, 0, 4'hE, 4'b0110, 2'b11, 0, 0, 0);
    step(1, 0, 0, 4'h0, 4'h0, 2'b00, 1, 0, 0);
    idle();

    // partial flag write
    do_reset();
    step(1, 0, 0, 4'hE, 4'b1011, 2'b10, 0, 0, 0);

    // failed condition
    step(1, 0, 0, 4'hE, 4'b0100, 2'b11, 0, 0, 0);
    step(1, 0, 0, 4'h1, 4'b1011, 2'b11, 0, 1, 0);

    // stall holds, flush beats stall
    step(1, 0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 1);
    step(1, 1, 0, 4'hE, 4'hF, 2'b11, 0, 0, 0);
    step(1, 0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 1);
    step(1, 1, 1, 4'hE, 4'hA, 2'b11, 0, 0, 1);
    idle();

    // sweep every cond code against every flag value
    for (int f = 0; f < 16; f++) begin
      step(1, 0, 0, 4'hE, 4'(f), 2'b11, 0, 0, 0);
      for (int c = 0; c < 16; c++)
        step(0, 0, 0, 4'(c), 4'h0, 2'b00, 1, 0, 0);
    end

    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0,
           4'($urandom), 4'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));

    // drive the counter into saturation
    while (mcnt != 16'hFFFF)
      step(1, 0, 0, 4'hF, 4'h0, 2'b11, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      step(1, 0, 0, 4'h1, 4'h4, 2'b11, 1, 1, 1);
    step(1, 0, 0, 4'hF, 4'h0, 2'b00, 0, 0, 0);

    w = 0;
    while ((qc.size() > 0 || qs.size() > 0) && w < 10) begin
      @(posedge clk);
      w++;
    end
    #3;
    total++;
    if (qc.size() == 0 && qs.size() == 0) passed++;
    else $display("FAIL drain: %0d/%0d left, expected 0",
                  qc.size(), qs.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Execute-stage condition unit; it consumes the ALU's 4-bit flag output.
- Holds the architectural NZCV flag register and evaluates the ARM 4-bit condition field against it.
- Gates the write-type controls (register write, memory write, PC source) for the instruction in Execute.
- Registers the gated controls into the Memory stage, with stall/flush handling and a saturating counter of condition-failed instructions.

Parameters:
- CNT_W, 16, width of the condition-failed instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- valid_e  in  1  Execute stage holds a real instruction
- stall_e  in  1  hold Execute/Memory state this cycle
- flush_e  in  1  squash the instruction in Execute
- cond_e  in  4  ARM condition field of the Execute instruction
- alu_flags  in  4  ALU flags: [3]=N, [2]=Z, [1]=C, [0]=V
- flag_w_e  in  2  [1] updates N,Z; [0] updates C,V
- pcs_e  in  1  instruction writes PC (branch or PC destination)
- reg_w_e  in  1  instruction writes the register file
- mem_w_e  in  1  instruction writes memory
- cond_ex_e  out  1  condition passed (combinational)
- pc_src_e  out  1  pcs_e gated by the condition (combinational)
- reg_write_m  out  1  registered gated register write
- mem_write_m  out  1  registered gated memory write
- pc_src_m  out  1  registered gated PC source
- flags  out  4  current NZCV flag register, same bit order as alu_flags
- fail_count  out  CNT_W  condition-failed instruction count

Behaviour:
- Reset (asynchronous, reset_n=0): flags=4'b0000; reg_write_m, mem_write_m and pc_src_m = 0; fail_count=0. Combinational outputs follow from the reset flags. Reset mid-operation discards any in-flight gating.
- Condition decode uses the flags register (not alu_flags):
  - 0 EQ: Z. 1 NE: ~Z. 2 CS: C. 3 CC: ~C.
  - 4 MI: N. 5 PL: ~N. 6 VS: V. 7 VC: ~V.
  - 8 HI: C&~Z. 9 LS: ~C|Z.
  - A GE: N==V. B LT: N!=V.
  - C GT: ~Z&(N==V). D LE: Z|(N!=V).
  - E AL: 1. F: 0 (never).
- Qualifiers:
  - go = valid_e & ~flush_e & cond_ex_e.
  - pc_src_e = pcs_e & go.
  - Gated reg and mem writes are reg_w_e & go and mem_w_e & go.
- Flag update at the clock edge when go & ~stall_e:
  - flag_w_e[1] loads flags[3:2] from alu_flags[3:2].
  - flag_w_e[0] loads flags[1:0] from alu_flags[1:0].
  - Other bits are held.
- Flag latency: the instruction in Execute in cycle t+1 sees flags written in cycle t; no bypass.
- Memory-stage registers:
  - flush_e=1: load 0 (bubble). flush_e has priority over stall_e.
  - Else stall_e=1: hold.
  - Else: load the gated values.
- Squashed or invalid instructions never update flags or fail_count, whatever flag_w_e says.
- fail_count increments when valid_e & ~flush_e & ~stall_e & ~cond_ex_e. It saturates at all-ones and never wraps.
- Latency: gated controls appear on the _m outputs 1 cycle after the Execute cycle.
- Pure sequential registers; no state machine beyond the flag, pipeline and counter registers.

Decomposition:
- Shared package:
  - Condition encodings COND_EQ..COND_AL, COND_NV.
  - Flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FlagW bit meanings.
- One natural sub-module: cond_check, a combinational decode of (cond, flags) to cond_ex. It is reusable by any later predication logic.

Test Plan:
1. Reset: hold reset_n=0 mid-stream with flags=4'b1111 -> flags=0, all _m outputs 0, fail_count=0 immediately (asynchronous).
2. CMP then BEQ:
   - Cycle 0: valid_e=1, flag_w_e=2'b11, cond_e=E, alu_flags=4'b0110 -> flags=4'b0110 after the edge.
   - Cycle 1: cond_e=0 (EQ), pcs_e=1 -> pc_src_e=1, and pc_src_m=1 one cycle later.
3. Partial write: flags=4'b0000; flag_w_e=2'b10, alu_flags=4'b1011 -> flags=4'b1000 (C,V untouched).
4. Failed condition:
   - Setup: flags=4'b0100, then cond_e=1 (NE), reg_w_e=1, flag_w_e=2'b11.
   - Expected: reg_write_m=0, flags unchanged, fail_count +1.
   - Repeat at fail_count=16'hFFFF -> stays 16'hFFFF.
5. Stall/flush priority:
   - stall_e=1 with AL, mem_w_e=1 -> mem_write_m holds its prior value and flags hold.
   - stall_e=1 with flush_e=1 -> mem_write_m=0 and no flag write.
6. Sweep all 16 cond_e codes × 16 flag values -> cond_ex_e matches the decode table; cond_e=F always gives 0.
